// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_LOAD = 2'b10
  } state_e;

endpackage

// File: rtl/fetch_sequencer_adder.sv
// Parameterised modulo-2^W adder used for PC increment.
module fetch_sequencer_adder #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC ownership, stall/redirect/halt resolution,
// and sharing of the instruction-memory port with a program loader.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_grant,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_din,
  output logic [ADDR_W-1:0] pc_fetch,
  output logic [ADDR_W-1:0] pc_plus_1,
  output logic              fetch_valid,
  output logic              flush_ifid,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_pc_q;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              r_fetch_valid;
  logic              w_fetch_valid_next;
  logic              r_load_grant;
  logic              r_halted;

  fetch_sequencer_adder #(.W(ADDR_W)) u_pc_inc (
    .i_a   (r_pc_q),
    .i_b   (ADDR_W'(1)),
    .o_sum (w_pc_inc)
  );

  // Next state, next PC and squash qualifier; RUN decisions follow strict priority.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc_q;
    w_fetch_valid_next = 1'b0;
    flush_ifid         = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_fetch_valid_next = 1'b1;
        if (halt_req) begin
          flush_ifid         = 1'b1;
          w_state_next       = ST_HALT;
          w_fetch_valid_next = 1'b0;
        end else if (redirect_valid) begin
          w_pc_next  = redirect_addr;
          flush_ifid = 1'b1;
        end else if (stall) begin
          w_fetch_valid_next = r_fetch_valid;
        end else if (r_fetch_valid) begin
          w_pc_next = w_pc_inc;
        end
      end
      ST_HALT: begin
        if (load_req) begin
          w_state_next = ST_LOAD;
        end else if (resume) begin
          w_state_next       = ST_RUN;
          w_fetch_valid_next = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!load_req) begin
          w_state_next = ST_HALT;
          w_pc_next    = PC_RST;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_pc_next    = PC_RST;
      end
    endcase
  end

  // Memory port: loader owns it in LOAD except on the exit cycle, which re-primes RESET_PC.
  always_comb begin
    imem_addr = w_pc_next;
    imem_we   = 1'b0;
    imem_din  = '0;
    if (r_state == ST_LOAD) begin
      if (load_req) begin
        imem_addr = load_addr;
      end
      imem_we  = load_we & r_load_grant;
      imem_din = load_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_pc_q        <= PC_RST;
      r_fetch_valid <= 1'b0;
      r_load_grant  <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc_q        <= w_pc_next;
      r_fetch_valid <= w_fetch_valid_next;
      r_load_grant  <= (w_state_next == ST_LOAD);
      r_halted      <= (w_state_next != ST_RUN);
    end
  end

  assign pc_fetch    = r_pc_q;
  assign pc_plus_1   = w_pc_inc;
  assign fetch_valid = r_fetch_valid;
  assign load_grant  = r_load_grant;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: cycle model plus directed literal checks.
module tb_fetch_sequencer;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_LOAD = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          load_req = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          load_grant;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [DW-1:0] imem_din;
  logic [AW-1:0] pc_fetch;
  logic [AW-1:0] pc_plus_1;
  logic          fetch_valid;
  logic          flush_ifid;
  logic          halted;

  int checks = 0;
  int errors = 0;

  // Abstract model state: mode, PC value, valid flag, grant flag.
  int m_mode  = M_RUN;
  int m_pc    = 0;
  bit m_fv    = 1'b0;
  bit m_grant = 1'b0;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .resume         (resume),
    .load_req       (load_req),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_grant     (load_grant),
    .imem_addr      (imem_addr),
    .imem_we        (imem_we),
    .imem_din       (imem_din),
    .pc_fetch       (pc_fetch),
    .pc_plus_1      (pc_plus_1),
    .fetch_valid    (fetch_valid),
    .flush_ifid     (flush_ifid),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mdl_pc_next();
    int r;
    r = m_pc;
    if (m_mode == M_RUN) begin
      if (halt_req)                 r = m_pc;
      else if (redirect_valid)      r = int'(redirect_addr);
      else if (stall || !m_fv)      r = m_pc;
      else                          r = (m_pc + 1) % 1024;
    end else if (m_mode == M_LOAD && !load_req) begin
      r = 0;
    end
    return r;
  endfunction

  function automatic int mdl_mode_next();
    int r;
    r = m_mode;
    if (m_mode == M_RUN)       r = halt_req ? M_HALT : M_RUN;
    else if (m_mode == M_HALT) r = load_req ? M_LOAD : (resume ? M_RUN : M_HALT);
    else                       r = load_req ? M_LOAD : M_HALT;
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_RUN; m_pc = 0; m_fv = 1'b0; m_grant = 1'b0;
    end else begin
      int nm, np;
      bit nf;
      nm = mdl_mode_next();
      np = mdl_pc_next();
      nf = (nm == M_RUN) && (m_mode == M_RUN || resume);
      if (m_mode == M_RUN && nm == M_RUN && !redirect_valid && stall) nf = m_fv;
      m_mode = nm; m_pc = np; m_fv = nf; m_grant = (nm == M_LOAD);
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clock) begin
    int ea;
    ea = (m_mode == M_LOAD && load_req) ? int'(load_addr) : mdl_pc_next();
    chk("pc_fetch", 32'(pc_fetch), 32'(m_pc));
    chk("pc_plus_1", 32'(pc_plus_1), 32'((m_pc + 1) % 1024));
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("halted", 32'(halted), 32'(m_mode != M_RUN));
    chk("load_grant", 32'(load_grant), 32'(m_grant));
    chk("imem_addr", 32'(imem_addr), 32'(ea));
    chk("flush_ifid", 32'(flush_ifid), 32'(m_mode == M_RUN && (halt_req || redirect_valid)));
    chk("imem_we", 32'(imem_we), 32'(m_mode == M_LOAD && load_we && m_grant));
    chk("imem_din", 32'(imem_din), (m_mode == M_LOAD) ? load_data : 32'h0);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("prime_addr", 32'(imem_addr), 32'h0);
    chk("prime_valid", 32'(fetch_valid), 32'h0);
    cyc(); chk("run_v0", 32'(fetch_valid), 32'h1); chk("run_pc0", 32'(pc_fetch), 32'h0);
    cyc(); chk("run_pc1", 32'(pc_fetch), 32'h1);
    cyc(); chk("run_pc2", 32'(pc_fetch), 32'h2);
    cyc(); chk("run_pc3", 32'(pc_fetch), 32'h3);
    cyc(); cyc(); chk("run_pc5", 32'(pc_fetch), 32'h5);

    stall = 1'b1;
    #1 chk("stall_addr", 32'(imem_addr), 32'h5);
    for (int i = 0; i < 2; i++) begin
      cyc(); chk("stall_pc", 32'(pc_fetch), 32'h5); chk("stall_v", 32'(fetch_valid), 32'h1);
    end
    cyc(); stall = 1'b0;
    chk("stall_end_pc", 32'(pc_fetch), 32'h5);
    cyc(); chk("after_stall_pc", 32'(pc_fetch), 32'h6);
    cyc(); chk("pc7", 32'(pc_fetch), 32'h7);

    redirect_valid = 1'b1; redirect_addr = 10'h200; stall = 1'b1;
    #1 chk("redir_flush", 32'(flush_ifid), 32'h1); chk("redir_addr", 32'(imem_addr), 32'h200);
    cyc(); redirect_valid = 1'b0; stall = 1'b0;
    chk("redir_pc", 32'(pc_fetch), 32'h200); chk("redir_v", 32'(fetch_valid), 32'h1);

    redirect_valid = 1'b1; redirect_addr = 10'h3FE;
    cyc(); redirect_valid = 1'b0;
    chk("wrap_3fe", 32'(pc_fetch), 32'h3FE);
    cyc(); chk("wrap_3ff", 32'(pc_fetch), 32'h3FF); chk("wrap_plus1", 32'(pc_plus_1), 32'h0);
    cyc(); chk("wrap_000", 32'(pc_fetch), 32'h0);

    redirect_valid = 1'b1; redirect_addr = 10'd9;
    cyc(); redirect_valid = 1'b0;
    chk("pc9", 32'(pc_fetch), 32'd9);
    halt_req = 1'b1;
    #1 chk("halt_flush", 32'(flush_ifid), 32'h1);
    cyc(); halt_req = 1'b0;
    chk("halt_h", 32'(halted), 32'h1); chk("halt_v", 32'(fetch_valid), 32'h0);
    chk("halt_pc", 32'(pc_fetch), 32'd9);
    redirect_valid = 1'b1; redirect_addr = 10'h55; stall = 1'b1; halt_req = 1'b1;
    #1 chk("halt_noflush", 32'(flush_ifid), 32'h0); chk("halt_addr", 32'(imem_addr), 32'd9);
    cyc(); cyc();
    redirect_valid = 1'b0; stall = 1'b0; halt_req = 1'b0;
    chk("halt_hold_pc", 32'(pc_fetch), 32'd9);
    resume = 1'b1;
    cyc(); resume = 1'b0;
    chk("resume_v", 32'(fetch_valid), 32'h1); chk("resume_pc", 32'(pc_fetch), 32'd9);
    chk("resume_h", 32'(halted), 32'h0);
    cyc(); chk("resume_pc10", 32'(pc_fetch), 32'd10);

    halt_req = 1'b1;
    cyc(); halt_req = 1'b0; load_req = 1'b1;
    cyc(); chk("grant", 32'(load_grant), 32'h1); chk("load_h", 32'(halted), 32'h1);
    for (int i = 0; i < 4; i++) begin
      load_we = 1'b1; load_addr = 10'(i); load_data = 32'(8'hA0 + i);
      #1;
      chk("ld_we", 32'(imem_we), 32'h1);
      chk("ld_addr", 32'(imem_addr), 32'(i));
      chk("ld_din", imem_din, 32'(8'hA0 + i));
      cyc();
    end
    load_we = 1'b0; load_req = 1'b0;
    #1 chk("ld_exit_addr", 32'(imem_addr), 32'h0); chk("ld_exit_we", 32'(imem_we), 32'h0);
    cyc(); chk("post_ld_pc", 32'(pc_fetch), 32'h0); chk("post_ld_h", 32'(halted), 32'h1);
    chk("post_ld_grant", 32'(load_grant), 32'h0);
    resume = 1'b1;
    cyc(); resume = 1'b0;
    chk("post_ld_v", 32'(fetch_valid), 32'h1); chk("post_ld_pc0", 32'(pc_fetch), 32'h0);
    cyc(); chk("post_ld_pc1", 32'(pc_fetch), 32'h1);

    halt_req = 1'b1;
    cyc(); halt_req = 1'b0; load_req = 1'b1;
    cyc(); chk("rerun_grant", 32'(load_grant), 32'h1);
    load_we = 1'b1; load_addr = 10'd7; load_data = 32'h77;
    #1 chk("rerun_we", 32'(imem_we), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_we", 32'(imem_we), 32'h0); chk("rst_grant", 32'(load_grant), 32'h0);
    chk("rst_h", 32'(halted), 32'h0); chk("rst_pc", 32'(pc_fetch), 32'h0);
    load_req = 1'b0; load_we = 1'b0;
    cyc(); reset_n = 1'b1;
    #1 chk("rst_prime_v", 32'(fetch_valid), 32'h0);
    cyc(); chk("rst_run_v", 32'(fetch_valid), 32'h1); chk("rst_run_pc0", 32'(pc_fetch), 32'h0);
    cyc(); chk("rst_run_pc1", 32'(pc_fetch), 32'h1);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
